evm_booth_arbiter: RTL

- Shares one EVM vote-count datapath between NUM_BOOTHS voting booths.
- Each booth has its own officer authorisation switch and candidate push-buttons.
- Grants booths round-robin, enforces one valid vote per authorisation, and issues single increment requests to the shared counter with a req/ack handshake.
- Sits between the booth panels and the vote-count/result-display block.

---
 rtl/evm_pkg.sv | 25 ++
 rtl/evm_rr_arbiter.sv | 34 +++
 rtl/evm_booth_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared types, defaults and helpers for the EVM booth arbiter
package evm_pkg;

  localparam int DEF_NUM_BOOTHS   = 4;
  localparam int DEF_NUM_CAND     = 3;
  localparam int DEF_VOTE_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_WAIT_VOTE = 3'd2,
    ST_COMMIT    = 3'd3,
    ST_CLOSED    = 3'd4
  } evm_state_e;

  // Index width for n items, never narrower than one bit
  function automatic int evm_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic evm_onehot_valid(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/evm_rr_arbiter.sv
// rtl/evm_rr_arbiter.sv - rotate-priority pick of the first pending booth at or after ptr
module evm_rr_arbiter
  import evm_pkg::*;
#(
  parameter int NUM_BOOTHS = DEF_NUM_BOOTHS,
  parameter int PTR_W      = evm_width(NUM_BOOTHS)
) (
  input  logic [NUM_BOOTHS-1:0] pending,
  input  logic [PTR_W-1:0]      ptr,
  output logic [NUM_BOOTHS-1:0] grant,
  output logic [PTR_W-1:0]      grant_idx,
  output logic                  grant_valid
);

  logic [PTR_W-1:0] cand_idx;

  // Scan farthest offset first so the nearest pending booth is the last write
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    for (int k = NUM_BOOTHS - 1; k >= 0; k--) begin
      cand_idx = PTR_W'((int'(ptr) + k) % NUM_BOOTHS);
      if (pending[cand_idx]) begin
        grant           = '0;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/evm_booth_arbiter.sv
// rtl/evm_booth_arbiter.sv - round-robin booth arbiter feeding one shared vote counter
// Optional audit counters are built when EVM_AUDIT_EN is defined.
module evm_booth_arbiter
  import evm_pkg::*;
#(
  parameter int NUM_BOOTHS   = DEF_NUM_BOOTHS,
  parameter int NUM_CAND     = DEF_NUM_CAND,
  parameter int VOTE_TIMEOUT = DEF_VOTE_TIMEOUT,
  parameter int CAND_W       = evm_width(NUM_CAND)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           session_open,
  input  logic                           session_close,
  input  logic [NUM_BOOTHS-1:0]          booth_ready,
  input  logic [NUM_BOOTHS*NUM_CAND-1:0] booth_vote,
  output logic                           cnt_req,
  output logic [CAND_W-1:0]              cnt_cand,
  input  logic                           cnt_ack,
  output logic [NUM_BOOTHS-1:0]          booth_grant,
  output logic [NUM_BOOTHS-1:0]          booth_pending,
  output logic                           invalid_vote,
  output logic                           vote_timeout,
  output logic                           session_active,
`ifdef EVM_AUDIT_EN
  output logic [15:0]                    audit_accepted,
  output logic [15:0]                    audit_rejected,
  output logic [7:0]                     audit_timeouts,
`endif
  output logic                           session_done
);

  localparam int PTR_W  = evm_width(NUM_BOOTHS);
  localparam int TMR_W  = evm_width(VOTE_TIMEOUT + 1);
  localparam int VOTE_W = NUM_BOOTHS * NUM_CAND;

  evm_state_e            state_q, state_d;
  logic [NUM_BOOTHS-1:0] pending_q, pending_d;
  logic [NUM_BOOTHS-1:0] grant_q, grant_d;
  logic [NUM_BOOTHS-1:0] ready_prev_q, ready_prev_d;
  logic [VOTE_W-1:0]     btn_prev_q, btn_prev_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  cnt_req_q, cnt_req_d;
  logic [CAND_W-1:0]     cnt_cand_q, cnt_cand_d;
  logic                  invalid_q, invalid_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_BOOTHS-1:0] arb_grant;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_valid;

  logic [NUM_CAND-1:0]   cur_btn, prev_btn;
  logic                  press;
  logic                  press_single;
  logic [CAND_W-1:0]     press_idx;
  logic                  in_session;

  evm_rr_arbiter #(
    .NUM_BOOTHS (NUM_BOOTHS),
    .PTR_W      (PTR_W)
  ) u_rr_arbiter (
    .pending     (pending_q),
    .ptr         (ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Only the granted booth's buttons reach the press detector
  always_comb begin
    cur_btn  = '0;
    prev_btn = '0;
    for (int b = 0; b < NUM_BOOTHS; b++) begin
      if (grant_q[b]) begin
        cur_btn  = cur_btn  | booth_vote[b*NUM_CAND +: NUM_CAND];
        prev_btn = prev_btn | btn_prev_q[b*NUM_CAND +: NUM_CAND];
      end
    end
    press        = (cur_btn != '0) && (prev_btn == '0);
    press_single = evm_onehot_valid(8'(cur_btn));
    press_idx    = '0;
    for (int c = 0; c < NUM_CAND; c++) begin
      if (cur_btn[c]) press_idx = CAND_W'(c);
    end
  end

  assign in_session = (state_q == ST_ARB) || (state_q == ST_WAIT_VOTE) || (state_q == ST_COMMIT);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    cnt_req_d    = cnt_req_q;
    cnt_cand_d   = cnt_cand_q;
    invalid_d    = 1'b0;
    timeout_d    = 1'b0;
    ready_prev_d = booth_ready;
    btn_prev_d   = booth_vote;

    if (in_session) begin
      pending_d = pending_q | (booth_ready & ~ready_prev_q & ~grant_q);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (session_open) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (session_close) begin
          state_d   = ST_CLOSED;
          pending_d = '0;
        end else if (arb_valid) begin
          grant_d = arb_grant;
          timer_d = '0;
          ptr_d   = (arb_idx == PTR_W'(NUM_BOOTHS - 1)) ? '0 : arb_idx + PTR_W'(1);
          state_d = ST_WAIT_VOTE;
        end
      end
      ST_WAIT_VOTE: begin
        timer_d = timer_q + TMR_W'(1);
        if (press && press_single) begin
          cnt_req_d  = 1'b1;
          cnt_cand_d = press_idx;
          state_d    = ST_COMMIT;
        end else begin
          if (press) invalid_d = 1'b1;
          if (timer_q == TMR_W'(VOTE_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            pending_d = pending_d & ~grant_q;
            grant_d   = '0;
            state_d   = ST_ARB;
          end
        end
      end
      ST_COMMIT: begin
        if (cnt_ack) begin
          cnt_req_d = 1'b0;
          pending_d = pending_d & ~grant_q;
          grant_d   = '0;
          state_d   = ST_ARB;
        end
      end
      ST_CLOSED: begin
        pending_d = '0;
        grant_d   = '0;
        cnt_req_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      grant_q      <= '0;
      ready_prev_q <= '0;
      btn_prev_q   <= '0;
      ptr_q        <= '0;
      timer_q      <= '0;
      cnt_req_q    <= 1'b0;
      cnt_cand_q   <= '0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      ready_prev_q <= ready_prev_d;
      btn_prev_q   <= btn_prev_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      cnt_req_q    <= cnt_req_d;
      cnt_cand_q   <= cnt_cand_d;
      invalid_q    <= invalid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cnt_req        = cnt_req_q;
  assign cnt_cand       = cnt_cand_q;
  assign booth_grant    = grant_q;
  assign booth_pending  = pending_q;
  assign invalid_vote   = invalid_q;
  assign vote_timeout   = timeout_q;
  assign session_active = in_session;
  assign session_done   = (state_q == ST_CLOSED);

`ifdef EVM_AUDIT_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] rej_q, rej_d;
  logic [7:0]  tmo_q, tmo_d;

  // Saturating event counters, cleared only by reset
  always_comb begin
    acc_d = acc_q;
    rej_d = rej_q;
    tmo_d = tmo_q;
    if ((state_q == ST_COMMIT) && cnt_ack && (acc_q != '1)) acc_d = acc_q + 16'd1;
    if (invalid_d && (rej_q != '1)) rej_d = rej_q + 16'd1;
    if (timeout_d && (tmo_q != '1)) tmo_d = tmo_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      rej_q <= '0;
      tmo_q <= '0;
    end else begin
      acc_q <= acc_d;
      rej_q <= rej_d;
      tmo_q <= tmo_d;
    end
  end

  assign audit_accepted = acc_q;
  assign audit_rejected = rej_q;
  assign audit_timeouts = tmo_q;
`endif

endmodule
